// File: rtl/generic_rom_pkg.sv
// Shared types and helpers for the generic ROM storage core and its backdoor decoder.
package generic_rom_pkg;

    typedef enum logic [1:0] {
        SZ8    = 2'd0,
        SZ16   = 2'd1,
        SZ32   = 2'd2,
        SZ_BAD = 2'd3
    } bd_size_e;

    localparam int WORD_BYTES = 4;

    // Byte-enable mask for an access of the given size starting at byte lane 'lane'.
    function automatic logic [WORD_BYTES-1:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        logic [WORD_BYTES-1:0] m;
        case (size)
            SZ8:     m = 4'b0001 << lane;
            SZ16:    m = lane[1] ? 4'b1100 : 4'b0011;
            SZ32:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/generic_rom_bd_decode.sv
// Backdoor address decode: range/alignment checking, byte enables and write-data lane steering.
module generic_rom_bd_decode
    import generic_rom_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 10
) (
    input  logic [1:0]               size,
    input  logic [63:0]              offset,
    input  logic [31:0]              wdata,
    output logic                     err,
    output logic [ADDRESS_WIDTH-1:0] word_index,
    output logic [1:0]               lane,
    output logic [3:0]               byte_en,
    output logic [31:0]              lane_wdata
);

    logic range_err_s;
    logic align_err_s;

    // Classify the request and build the byte-lane view of the write data.
    always_comb begin
        range_err_s = ((offset >> (ADDRESS_WIDTH + 2)) != 64'd0);
        case (size)
            SZ8:     align_err_s = 1'b0;
            SZ16:    align_err_s = offset[0];
            SZ32:    align_err_s = (offset[1:0] != 2'd0);
            default: align_err_s = 1'b1;
        endcase
        err        = range_err_s | align_err_s;
        word_index = offset[ADDRESS_WIDTH+1:2];
        lane       = offset[1:0];
        byte_en    = err ? 4'b0000 : lane_mask(size, offset[1:0]);
        // Replicate narrow data across all lanes; byte_en picks the live ones.
        case (size)
            SZ8:     lane_wdata = {4{wdata[7:0]}};
            SZ16:    lane_wdata = {2{wdata[15:0]}};
            SZ32:    lane_wdata = wdata;
            default: lane_wdata = 32'd0;
        endcase
    end

endmodule

// File: rtl/generic_rom_store.sv
// Word-addressed ROM storage core: synchronous read port, byte-granular backdoor, init bitmap.
module generic_rom_store
    import generic_rom_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 10,
    parameter int DATA_WIDTH    = 32,
    parameter int REPORT_UNINIT = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [ADDRESS_WIDTH-1:0] i_address,
    output logic [DATA_WIDTH-1:0]    o_read_data,
    output logic                     o_uninit,
    input  logic                     i_bd_req,
    input  logic                     i_bd_we,
    input  logic [1:0]               i_bd_size,
    input  logic [63:0]              i_bd_offset,
    input  logic [31:0]              i_bd_wdata,
    output logic                     o_bd_ack,
    output logic [31:0]              o_bd_rdata,
    output logic                     o_bd_err
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("generic_rom_store: only DATA_WIDTH = 32 is supported");
    end

    logic [DATA_WIDTH-1:0]    rom_r [0:DEPTH-1];
    logic [DEPTH-1:0]         init_r;
    logic [DATA_WIDTH-1:0]    read_data_r;
    logic                     uninit_r;
    logic                     bd_ack_r;
    logic [31:0]              bd_rdata_r;
    logic                     bd_err_r;

    logic                     dec_err_s;
    logic [ADDRESS_WIDTH-1:0] word_index_s;
    logic [1:0]               lane_s;
    logic [3:0]               byte_en_s;
    logic [31:0]              lane_wdata_s;
    logic                     wr_en_s;
    logic [31:0]              bd_word_s;
    logic [31:0]              bd_extract_s;
    logic                     report_s;

    generic_rom_bd_decode #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_decode (
        .size       (i_bd_size),
        .offset     (i_bd_offset),
        .wdata      (i_bd_wdata),
        .err        (dec_err_s),
        .word_index (word_index_s),
        .lane       (lane_s),
        .byte_en    (byte_en_s),
        .lane_wdata (lane_wdata_s)
    );

    // Backdoor write qualification and zero-extended read extraction.
    always_comb begin
        report_s = (REPORT_UNINIT != 0);
        wr_en_s  = i_bd_req & i_bd_we & ~dec_err_s & ~i_rst;
        bd_word_s = rom_r[word_index_s];
        case (i_bd_size)
            SZ8:     bd_extract_s = {24'd0, bd_word_s[{lane_s, 3'b000} +: 8]};
            SZ16:    bd_extract_s = {16'd0, bd_word_s[{lane_s[1], 4'b0000} +: 16]};
            SZ32:    bd_extract_s = bd_word_s;
            default: bd_extract_s = 32'd0;
        endcase
    end

    // Storage array: never reset, byte lanes written individually so untouched bytes keep their value.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (wr_en_s && byte_en_s[b]) begin
                rom_r[word_index_s][8*b +: 8] <= lane_wdata_s[8*b +: 8];
            end
        end
    end

    // Init bitmap: cleared by reset, set by any successful backdoor write.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            init_r <= '0;
        end else if (wr_en_s) begin
            init_r[word_index_s] <= 1'b1;
        end else begin
            init_r <= init_r;
        end
    end

    // Read port: one-cycle latency; sees pre-write data and init state on a same-word collision.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            read_data_r <= '0;
            uninit_r    <= 1'b0;
        end else begin
            read_data_r <= rom_r[i_address];
            uninit_r    <= report_s & ~init_r[i_address];
        end
    end

    // Backdoor response: one ack pulse per accepted request, requests during reset are dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bd_ack_r   <= 1'b0;
            bd_rdata_r <= 32'd0;
            bd_err_r   <= 1'b0;
        end else if (i_bd_req) begin
            bd_ack_r   <= 1'b1;
            bd_err_r   <= dec_err_s;
            bd_rdata_r <= (dec_err_s || i_bd_we) ? 32'd0 : bd_extract_s;
        end else begin
            bd_ack_r   <= 1'b0;
            bd_rdata_r <= 32'd0;
            bd_err_r   <= 1'b0;
        end
    end

    assign o_read_data = read_data_r;
    assign o_uninit    = uninit_r;
    assign o_bd_ack    = bd_ack_r;
    assign o_bd_rdata  = bd_rdata_r;
    assign o_bd_err    = bd_err_r;

endmodule

// File: tb/tb_generic_rom_store.sv
// Directed scoreboard bench for generic_rom_store with REPORT_UNINIT enabled.
module tb_generic_rom_store;

    localparam int AW = 10;

    logic          i_clk;
    logic          i_rst;
    logic [AW-1:0] i_address;
    logic [31:0]   o_read_data;
    logic          o_uninit;
    logic          i_bd_req;
    logic          i_bd_we;
    logic [1:0]    i_bd_size;
    logic [63:0]   i_bd_offset;
    logic [31:0]   i_bd_wdata;
    logic          o_bd_ack;
    logic [31:0]   o_bd_rdata;
    logic          o_bd_err;

    typedef struct {
        string       tag;
        bit          chk_data;
        logic [31:0] data;
        logic        uninit;
    } rd_exp_t;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
    } bd_exp_t;

    rd_exp_t rd_q[$];
    bd_exp_t bd_q[$];
    int      n_assert = 0;
    int      n_fail   = 0;

    generic_rom_store #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (32),
        .REPORT_UNINIT (1)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_address   (i_address),
        .o_read_data (o_read_data),
        .o_uninit    (o_uninit),
        .i_bd_req    (i_bd_req),
        .i_bd_we     (i_bd_we),
        .i_bd_size   (i_bd_size),
        .i_bd_offset (i_bd_offset),
        .i_bd_wdata  (i_bd_wdata),
        .o_bd_ack    (o_bd_ack),
        .o_bd_rdata  (o_bd_rdata),
        .o_bd_err    (o_bd_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue_rd(input string tag, input logic [AW-1:0] addr, input bit chk_data,
                            input logic [31:0] data, input logic uninit);
        rd_exp_t e;
        i_address  = addr;
        e.tag      = tag;
        e.chk_data = chk_data;
        e.data     = data;
        e.uninit   = uninit;
        rd_q.push_back(e);
    endtask

    task automatic issue_bd(input string tag, input logic we, input logic [1:0] size,
                            input logic [63:0] off, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata, input logic exp_err);
        bd_exp_t e;
        i_bd_req    = 1'b1;
        i_bd_we     = we;
        i_bd_size   = size;
        i_bd_offset = off;
        i_bd_wdata  = wdata;
        e.tag       = tag;
        e.rdata     = exp_rdata;
        e.err       = exp_err;
        bd_q.push_back(e);
    endtask

    // One clock: inputs set before the rising edge, outputs compared on the falling edge.
    task automatic tick();
        rd_exp_t r;
        bd_exp_t b;
        @(posedge i_clk);
        @(negedge i_clk);
        i_bd_req = 1'b0;
        if (rd_q.size() > 0) begin
            r = rd_q.pop_front();
            if (r.chk_data) chk({r.tag, "_data"}, o_read_data, r.data);
            chk({r.tag, "_uninit"}, {31'd0, o_uninit}, {31'd0, r.uninit});
        end
        if (bd_q.size() > 0) begin
            b = bd_q.pop_front();
            chk({b.tag, "_ack"}, {31'd0, o_bd_ack}, 32'd1);
            chk({b.tag, "_rdata"}, o_bd_rdata, b.rdata);
            chk({b.tag, "_err"}, {31'd0, o_bd_err}, {31'd0, b.err});
        end else begin
            chk("idle_ack", {31'd0, o_bd_ack}, 32'd0);
        end
    endtask

    initial begin
        i_rst       = 1'b1;
        i_address   = '0;
        i_bd_req    = 1'b0;
        i_bd_we     = 1'b0;
        i_bd_size   = 2'd0;
        i_bd_offset = 64'd0;
        i_bd_wdata  = 32'd0;

        // Reset with a request held: it must be dropped.
        @(negedge i_clk);
        i_bd_req = 1'b1; i_bd_we = 1'b1; i_bd_size = 2'd2; i_bd_offset = 64'h10; i_bd_wdata = 32'h0BAD_0BAD;
        tick();
        i_bd_req = 1'b1;
        tick();
        chk("rst_read_data", o_read_data, 32'd0);
        chk("rst_uninit", {31'd0, o_uninit}, 32'd0);
        chk("rst_bd_rdata", o_bd_rdata, 32'd0);
        chk("rst_bd_err", {31'd0, o_bd_err}, 32'd0);
        i_rst = 1'b0;
        tick();

        // Basic write then read-port read.
        issue_bd("wr32_10", 1'b1, 2'd2, 64'h10, 32'hDEAD_BEEF, 32'd0, 1'b0); tick();
        issue_rd("rd_a4", 10'd4, 1'b1, 32'hDEAD_BEEF, 1'b0); tick();

        // Byte merge.
        issue_bd("wr32_0", 1'b1, 2'd2, 64'h0, 32'h1122_3344, 32'd0, 1'b0); tick();
        issue_bd("wr8_2", 1'b1, 2'd0, 64'h2, 32'hFFFF_FFAA, 32'd0, 1'b0); tick();
        issue_bd("rd32_merge", 1'b0, 2'd2, 64'h0, 32'd0, 32'h11AA_3344, 1'b0); tick();

        // Size and lane extraction.
        issue_bd("wr32_0b", 1'b1, 2'd2, 64'h0, 32'h1122_3344, 32'd0, 1'b0); tick();
        issue_bd("rd16_2", 1'b0, 2'd1, 64'h2, 32'd0, 32'h0000_1122, 1'b0); tick();
        issue_bd("rd8_1", 1'b0, 2'd0, 64'h1, 32'd0, 32'h0000_0033, 1'b0); tick();

        // Error cases leave memory untouched.
        issue_bd("wr32_mis", 1'b1, 2'd2, 64'h3, 32'hFFFF_FFFF, 32'd0, 1'b1); tick();
        issue_bd("wr16_odd", 1'b1, 2'd1, 64'h1, 32'hFFFF_FFFF, 32'd0, 1'b1); tick();
        issue_bd("wr_range", 1'b1, 2'd2, 64'd4 << AW, 32'hFFFF_FFFF, 32'd0, 1'b1); tick();
        issue_bd("rd_range_hi", 1'b0, 2'd0, 64'h8000_0000_0000_0000, 32'd0, 32'd0, 1'b1); tick();
        issue_bd("size3", 1'b0, 2'd3, 64'h0, 32'd0, 32'd0, 1'b1); tick();
        issue_bd("rd32_after_err", 1'b0, 2'd2, 64'h0, 32'd0, 32'h1122_3344, 1'b0); tick();
        issue_rd("rd_a0", 10'd0, 1'b1, 32'h1122_3344, 1'b0); tick();

        // Uninitialised tracking.
        issue_rd("rd_a7_uninit", 10'd7, 1'b0, 32'd0, 1'b1); tick();
        issue_bd("wr8_1c", 1'b1, 2'd0, 64'h1C, 32'h0000_005A, 32'd0, 1'b0); tick();
        issue_rd("rd_a7_init", 10'd7, 1'b0, 32'd0, 1'b0); tick();
        issue_bd("rd8_1c", 1'b0, 2'd0, 64'h1C, 32'd0, 32'h0000_005A, 1'b0); tick();
        i_rst = 1'b1; tick();
        i_rst = 1'b0;
        issue_rd("rd_a7_after_rst", 10'd7, 1'b0, 32'd0, 1'b1); tick();
        issue_rd("rd_a4_kept", 10'd4, 1'b1, 32'hDEAD_BEEF, 1'b1); tick();

        // Collisions: read port sees old init state and old data.
        issue_rd("col_init_old", 10'd3, 1'b0, 32'd0, 1'b1);
        issue_bd("col_wr_a", 1'b1, 2'd2, 64'hC, 32'h1234_5678, 32'd0, 1'b0); tick();
        issue_rd("col_data_old", 10'd3, 1'b1, 32'h1234_5678, 1'b0);
        issue_bd("col_wr_b", 1'b1, 2'd2, 64'hC, 32'h0000_0055, 32'd0, 1'b0); tick();
        issue_rd("col_data_new", 10'd3, 1'b1, 32'h0000_0055, 1'b0); tick();

        // Back-to-back requests give back-to-back acks, then idle.
        issue_bd("b2b_wr16", 1'b1, 2'd1, 64'h22, 32'h0000_BEEF, 32'd0, 1'b0); tick();
        issue_bd("b2b_rd16", 1'b0, 2'd1, 64'h22, 32'd0, 32'h0000_BEEF, 1'b0); tick();
        issue_bd("b2b_rd8", 1'b0, 2'd0, 64'h23, 32'd0, 32'h0000_00BE, 1'b0); tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
